// File: rtl/set_cmd_dispatcher_if.sv
// set_cmd_dispatcher_if: host-side command and result streams of set_cmd_dispatcher.
// The master is the host and the slave is the dispatcher.
interface set_cmd_dispatcher_if #(
  parameter int unsigned TAG_W = 4
) ();

  // Command stream: host to dispatcher
  logic             cmd_valid;
  logic             cmd_ready;
  logic [23:0]      cmd_central;
  logic [11:0]      cmd_radius;
  logic [1:0]       cmd_mode;

  // Result stream: dispatcher to host
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_candidate;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;

  modport master (
    output cmd_valid, cmd_central, cmd_radius, cmd_mode, res_ready,
    input  cmd_ready, res_valid, res_candidate, res_tag, res_err
  );

  modport slave (
    input  cmd_valid, cmd_central, cmd_radius, cmd_mode, res_ready,
    output cmd_ready, res_valid, res_candidate, res_tag, res_err
  );

endinterface

// File: rtl/set_cmd_dispatcher.sv
// set_cmd_dispatcher: buffers circle-set queries from the host in a small FIFO,
// issues them one at a time to SET and returns each candidate count as a
// tagged result, strictly in command order.
// Optional watchdog: define SETDISP_TIMEOUT_EN to turn a silent SET into an
// error result (candidate 8'hFF, err=1) after TIMEOUT wait cycles.
module set_cmd_dispatcher #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  set_cmd_dispatcher_if.slave host,
  output logic                set_en,
  output logic [23:0]         set_central,
  output logic [11:0]         set_radius,
  output logic [1:0]          set_mode,
  input  logic                set_busy,
  input  logic                set_valid,
  input  logic [7:0]          set_candidate
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("set_cmd_dispatcher: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1) begin : g_timeout_check
    $error("set_cmd_dispatcher: TIMEOUT must be >= 1");
  end

  typedef struct packed {
    logic [23:0]      central;
    logic [11:0]      radius;
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  entry_t           mem [DEPTH];
  entry_t           wdata;
  entry_t           iss;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic [TAG_W-1:0] tag;
  logic             push;
  logic             pop;
  logic             res_load;
  logic [7:0]       res_candidate_n;
  logic             res_err_n;

  assign push  = host.cmd_valid & host.cmd_ready;
  assign wdata = '{central: host.cmd_central, radius: host.cmd_radius,
                   mode: host.cmd_mode, tag: tag};

`ifdef SETDISP_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] wd_cnt;
  logic            wd_expire;

  assign wd_expire = (wd_cnt == TO_W'(TIMEOUT - 1));

  // Watchdog: counts WAIT cycles, held at zero elsewhere so it restarts on entry
  always_ff @(posedge clk) begin
    if (rst || state != WAIT) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + TO_W'(1);
    end
  end
`endif

  // Occupancy after this edge's push/pop
  always_comb begin
    count_n = count;
    if (push && !pop) begin
      count_n = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_n = count - CNT_W'(1);
    end
  end

  // FIFO pointers, occupancy, tag counter and registered ready
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      tag            <= '0;
      host.cmd_ready <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        tag    <= tag + TAG_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count          <= count_n;
      host.cmd_ready <= (count_n < CNT_W'(DEPTH));
    end
  end

  // FIFO storage; contents are meaningless while the occupancy says empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next state, FIFO pop and result capture decisions
  always_comb begin
    state_n         = state;
    pop             = 1'b0;
    res_load        = 1'b0;
    res_candidate_n = set_candidate;
    res_err_n       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0 && !set_busy && !host.res_valid) begin
          state_n = ISSUE;
          pop     = 1'b1;
        end
      end
      ISSUE: begin
        state_n = WAIT;
      end
      WAIT: begin
        if (set_valid) begin
          state_n  = IDLE;
          res_load = 1'b1;
        end
`ifdef SETDISP_TIMEOUT_EN
        else if (wd_expire) begin
          state_n         = IDLE;
          res_load        = 1'b1;
          res_candidate_n = 8'hFF;
          res_err_n       = 1'b1;
        end
`endif
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Issue registers, SET query outputs and the held result
  always_ff @(posedge clk) begin
    if (rst) begin
      iss                <= '0;
      set_en             <= 1'b0;
      set_central        <= '0;
      set_radius         <= '0;
      set_mode           <= '0;
      host.res_valid     <= 1'b0;
      host.res_candidate <= '0;
      host.res_tag       <= '0;
      host.res_err       <= 1'b0;
    end else begin
      if (pop) begin
        iss <= mem[rd_ptr];
      end
      set_en <= (state == ISSUE);
      if (state == ISSUE) begin
        set_central <= iss.central;
        set_radius  <= iss.radius;
        set_mode    <= iss.mode;
      end else begin
        set_central <= '0;
        set_radius  <= '0;
        set_mode    <= '0;
      end
      if (res_load) begin
        host.res_valid     <= 1'b1;
        host.res_candidate <= res_candidate_n;
        host.res_tag       <= iss.tag;
        host.res_err       <= res_err_n;
      end else if (host.res_valid && host.res_ready) begin
        host.res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_set_cmd_dispatcher.sv
// tb_set_cmd_dispatcher: random and directed commands against a behavioural
// SET stub; expected issues and results come from command queues in the bench.
module tb_set_cmd_dispatcher;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned TIMEOUT = 16;

  typedef struct packed {
    logic [23:0]      central;
    logic [11:0]      radius;
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  set_cmd_dispatcher_if #(.TAG_W(TAG_W)) host ();

  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_busy;
  logic        set_valid;
  logic [7:0]  set_candidate;

  set_cmd_dispatcher #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .host(host),
    .set_en(set_en), .set_central(set_central), .set_radius(set_radius),
    .set_mode(set_mode), .set_busy(set_busy), .set_valid(set_valid),
    .set_candidate(set_candidate)
  );

  int               n_vec    = 0;
  int               n_err    = 0;
  int               n_issue  = 0;
  int               n_pushed = 0;
  logic [TAG_W-1:0] mtag     = '0;
  cmd_t             exp_q[$];
  cmd_t             iss_q[$];

  logic       stub_busy   = 1'b0;
  logic       stub_valid  = 1'b0;
  logic       stray_valid = 1'b0;
  logic       hold_busy   = 1'b0;
  logic       stub_silent = 1'b0;
  logic       rand_ready  = 1'b0;
  logic [7:0] stub_cand   = 8'h00;
  int         stub_cnt    = 0;

  assign set_busy      = stub_busy | hold_busy;
  assign set_valid     = stub_valid | stray_valid;
  assign set_candidate = stub_valid ? stub_cand : 8'hA5;

  // Stand-in for SET's candidate count: any fixed function of the query works
  function automatic logic [7:0] set_ref(input logic [23:0] c, input logic [11:0] r,
                                         input logic [1:0] m);
    return (c[23:16] ^ c[15:8] ^ c[7:0]) + r[11:4] + {r[3:0], 2'b00, m};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SET stub: busy from en until a one-cycle valid after a random latency
  always @(negedge clk) begin
    stub_valid = 1'b0;
    if (rst) begin
      stub_busy = 1'b0;
      stub_cnt  = 0;
    end else begin
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          stub_valid = 1'b1;
          stub_busy  = 1'b0;
        end
      end
      if (set_en && !stub_silent) begin
        stub_busy = 1'b1;
        stub_cnt  = int'($urandom_range(1, 5));
        stub_cand = set_ref(set_central, set_radius, set_mode);
      end
    end
  end

  // Monitor: issue order/fields and result contents against the command queues
  always @(negedge clk) begin : mon
    cmd_t ic;
    cmd_t ec;
    #1;
    if (!rst) begin
      if (set_en) begin
        n_issue++;
        if (iss_q.size() == 0) begin
          check("spurious_en", 64'(set_en), 64'(0));
        end else begin
          ic = iss_q.pop_front();
          check("issue_fields", 64'({set_central, set_radius, set_mode}),
                64'({ic.central, ic.radius, ic.mode}));
        end
      end else begin
        check("idle_fields_zero", 64'({set_central, set_radius, set_mode}), 64'(0));
      end
      if (host.res_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_res", 64'(host.res_valid), 64'(0));
        end else begin
          ec = exp_q[0];
          check("res_tag", 64'(host.res_tag), 64'(ec.tag));
          check("res_cand", 64'(host.res_candidate),
                stub_silent ? 64'(8'hFF) : 64'(set_ref(ec.central, ec.radius, ec.mode)));
          check("res_err", 64'(host.res_err), 64'(stub_silent));
          if (host.res_ready) begin
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic push_cmd(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    int   waited;
    cmd_t e;
    waited = 0;
    host.cmd_valid   = 1'b1;
    host.cmd_central = c;
    host.cmd_radius  = r;
    host.cmd_mode    = m;
    while (!host.cmd_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!host.cmd_ready) begin
      check("push_stall", 64'(host.cmd_ready), 64'(1));
    end else begin
      @(posedge clk);
      e = '{central: c, radius: r, mode: m, tag: mtag};
      exp_q.push_back(e);
      iss_q.push_back(e);
      mtag = mtag + TAG_W'(1);
      n_pushed++;
    end
    @(negedge clk);
    host.cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || host.res_valid) && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    check({tag, "_drain"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic wait_issue(input string tag, input int base);
    int n;
    n = 0;
    while (n_issue == base && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    check(tag, 64'(n_issue), 64'(base + 1));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, 64'(host.cmd_ready), 64'(1));
    check({tag, "_set_en"}, 64'(set_en), 64'(0));
    check({tag, "_set_fields"}, 64'({set_central, set_radius, set_mode}), 64'(0));
    check({tag, "_res_valid"}, 64'(host.res_valid), 64'(0));
    check({tag, "_res_cand"}, 64'(host.res_candidate), 64'(0));
    check({tag, "_res_tag"}, 64'(host.res_tag), 64'(0));
    check({tag, "_res_err"}, 64'(host.res_err), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    iss_q.delete();
    mtag = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    int b_iss;
    int b_push;
    int n;
    host.cmd_valid   = 1'b0;
    host.cmd_central = '0;
    host.cmd_radius  = '0;
    host.cmd_mode    = '0;
    host.res_ready   = 1'b1;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    check_reset_vals("reset");

    // Directed queries; first one also checks issue latency
    push_cmd(24'h550000, 12'h300, 2'd0);
    #2;
    check("lat_e0", 64'(set_en), 64'(0));
    @(negedge clk); #2;
    check("lat_e1", 64'(set_en), 64'(0));
    @(negedge clk); #2;
    check("lat_e2", 64'(set_en), 64'(1));
    push_cmd(24'h553300, 12'h330, 2'd1);
    push_cmd(24'h553300, 12'h330, 2'd2);
    push_cmd(24'h553362, 12'h332, 2'd3);
    wait_drain("directed");

    // SET held busy: FIFO fills, fifth command waits for space
    @(negedge clk);
    hold_busy = 1'b1;
    b_iss  = n_issue;
    b_push = n_pushed;
    for (int i = 0; i < 4; i++) push_cmd(24'($urandom), 12'($urandom), 2'($urandom));
    #2;
    check("full_ready", 64'(host.cmd_ready), 64'(0));
    fork
      push_cmd(24'h123456, 12'hABC, 2'd1);
    join_none
    repeat (6) @(negedge clk);
    #2;
    check("full_ready_held", 64'(host.cmd_ready), 64'(0));
    check("full_held_off", 64'(n_pushed), 64'(b_push + 4));
    check("busy_no_issue", 64'(n_issue), 64'(b_iss));
    hold_busy = 1'b0;
    wait_drain("busy");
    check("busy_issue_cnt", 64'(n_issue), 64'(b_iss + 5));

    // Result back-pressure blocks further issues
    @(negedge clk);
    host.res_ready = 1'b0;
    b_iss = n_issue;
    push_cmd(24'h0A0B0C, 12'h456, 2'd2);
    push_cmd(24'hFEDCBA, 12'h789, 2'd3);
    n = 0;
    while (!host.res_valid && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    repeat (8) @(negedge clk);
    #2;
    check("stall_valid", 64'(host.res_valid), 64'(1));
    check("stall_no_issue", 64'(n_issue), 64'(b_iss + 1));
    @(negedge clk);
    host.res_ready = 1'b1;
    @(negedge clk); #2;
    check("reissue_e1", 64'(set_en), 64'(0));
    @(negedge clk); #2;
    check("reissue_e2", 64'(set_en), 64'(0));
    @(negedge clk); #2;
    check("reissue_e3", 64'(set_en), 64'(1));
    wait_drain("stall");

    // Random commands with random result back-pressure and SET busy
    rand_ready = 1'b1;
    fork
      begin
        while (rand_ready) begin
          @(negedge clk);
          if (rand_ready) begin
            host.res_ready = ($urandom_range(0, 3) != 0);
            hold_busy      = ($urandom_range(0, 5) == 0);
          end
        end
      end
    join_none
    for (int i = 0; i < 20; i++) push_cmd(24'($urandom), 12'($urandom), 2'($urandom));
    rand_ready = 1'b0;
    repeat (2) @(negedge clk);
    host.res_ready = 1'b1;
    hold_busy      = 1'b0;
    wait_drain("random");

    // Reset while waiting on SET, then a stray valid pulse
    do_reset();
    #2;
    check_reset_vals("reset2");
    stub_silent = 1'b1;
    b_iss = n_issue;
    push_cmd(24'h314159, 12'h265, 2'd1);
    wait_issue("rst_issued", b_iss);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    iss_q.delete();
    mtag = '0;
    @(negedge clk);
    rst = 1'b0;
    stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    #2;
    check_reset_vals("rst_wait");
    repeat (4) @(negedge clk);
    #2;
    check("stray_ignored", 64'(host.res_valid), 64'(0));

    // Silent SET: watchdog result, or an indefinite wait without it
    b_iss = n_issue;
    push_cmd(24'hABCDEF, 12'h123, 2'd2);
    wait_issue("to_issued", b_iss);
    repeat (15) @(negedge clk);
    #2;
    check("to_pre", 64'(host.res_valid), 64'(0));
`ifdef SETDISP_TIMEOUT_EN
    @(negedge clk); #2;
    check("to_fire", 64'(host.res_valid), 64'(1));
    check("to_cand", 64'(host.res_candidate), 64'(8'hFF));
    check("to_err", 64'(host.res_err), 64'(1));
    check("to_tag", 64'(host.res_tag), 64'(0));
    wait_drain("timeout");
`else
    repeat (40) @(negedge clk);
    #2;
    check("no_timeout_hold", 64'(host.res_valid), 64'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
